display_annot_scheduler: RTL and testbench
==========================================

Name: display_annot_scheduler

Overview:
- Frame-level sequencer that multiplexes three 64-bit sources (bbox results, camera pixels, logo pixels) into the single typed-packet stream consumed by the display annotator.
- Each packet is one header word carrying the packet type, a fixed-length payload, then one trailer word with last=1.
- Sits between the inference/DMA read masters and the annotator input port. Packet order is fixed per frame: optional BBOX, then IMAGE, then optional LOGO.

Parameters:
- FRAME_WIDTH, 540, image width in pixels (2 pixels per word)
- FRAME_HEIGHT, 540, image height in pixels
- MAX_BBOX, 16, bbox payload words per BBOX packet
- LOGO_WIDTH, 540, logo width in pixels
- LOGO_HEIGHT, 100, logo height in pixels

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  single-cycle pulse; begins one frame sequence
- logo_en  in  1  include LOGO packet; sampled at frame_start acceptance
- bbox_upd  in  1  pulse; new bbox set available (sets sticky pending flag)
- bbox_valid / bbox_data / bbox_ready  in / in / out  1 / 64 / 1  bbox source
- img_valid / img_data / img_ready  in / in / out  1 / 64 / 1  pixel source
- logo_valid / logo_data / logo_ready  in / in / out  1 / 64 / 1  logo source
- out_valid  out  1  output word valid
- out_data  out  64  output word
- out_last  out  1  marks trailer word
- out_ready  in  1  downstream ready
- busy  out  1  sequence in progress
- overrun  out  1  one-cycle pulse; frame_start dropped because busy

Behaviour:
- Type codes: IMAGE=1, BBOX=2, LOGO=3, carried in header word bits [2:0]. Bits [63:3] are zero. Trailer data is all zero.
- Payload counts: IMAGE = FRAME_WIDTH*FRAME_HEIGHT/2 (145800). BBOX = MAX_BBOX. LOGO = LOGO_WIDTH*LOGO_HEIGHT/2 (27000).
- Counter is 22 bits. Elaboration error if any count >= 2^22.
- FSM states: IDLE, SEL, HDR, PAYLOAD, TRAILER.
- IDLE:
  - frame_start -> SEL.
  - Latch logo_en into logo_q.
  - Set sel to BBOX if bbox_pend, else IMAGE.
- HDR:
  - out_valid=1, out_data={61'b0,sel}, out_last=0.
  - On out_ready: go to PAYLOAD and clear counter.
- PAYLOAD:
  - Combinational pass-through of the selected source: out_valid = src_valid, out_data = src_data, src_ready = out_ready.
  - Non-selected sources see ready=0.
  - Counter increments on each accepted beat.
  - The beat where counter == count-1 moves the FSM to TRAILER.
  - No timeout: a stalled source stalls the sequence indefinitely.
- TRAILER:
  - out_valid=1, out_data=0, out_last=1.
  - On out_ready, next packet is chosen: after BBOX -> IMAGE (via HDR); after IMAGE -> LOGO if logo_q, else IDLE; after LOGO -> IDLE.
- SEL is a one-cycle registered stage before HDR.
- bbox_pend:
  - Set by bbox_upd.
  - Cleared on acceptance of the BBOX header word.
  - If bbox_upd coincides with that clear, set wins: the new set is kept for the next frame.
- frame_start while not IDLE: ignored, overrun=1 for that cycle. There is no queuing.
- out_last is 0 in every state except TRAILER.
- out_valid is 0 in IDLE and SEL.
- busy = (state != IDLE).
- Reset, in any state including mid-packet:
  - state=IDLE, counter=0, bbox_pend=0, logo_q=0, overrun=0.
  - out_valid=0, out_last=0, all src_ready=0.
  - Partial packets are abandoned; the downstream is reset together with this block.
- Holding rules while out_ready=0:
  - out_data and out_last stay stable while out_valid=1.
  - Generated words (HDR/TRAILER) never deassert valid before acceptance.

Decomposition:
- Shared package display_annot_pkg holds:
  - type-code constants PKT_IMAGE / PKT_BBOX / PKT_LOGO
  - state encoding
  - payload-count functions
- The annotator must import the same codes.
- One natural sub-module: display_annot_src_mux, a combinational 3:1 valid/data/ready steering block selected by sel.
- FSM and counter remain in the top block.

Test Plan:
- bbox_upd, then frame_start, logo_en=0, all sources always valid, out_ready=1 -> stream is:
  - BBOX header 0x2 + 16 beats + trailer
  - IMAGE header 0x1 + 145800 beats + trailer
  - then IDLE; bbox_pend=0.
- frame_start with no bbox_upd, logo_en=1 -> IMAGE packet, then LOGO header 0x3 + 27000 beats + trailer; no BBOX header.
- Random out_ready (50%) and random img_valid gaps:
  - 145800 payload beats exactly, in order, data matches the source.
  - Outputs stable while stalled.
  - img_ready low outside IMAGE PAYLOAD.
- frame_start pulsed during IMAGE payload -> overrun=1 for one cycle; sequence unchanged; no second frame starts.
- bbox_upd asserted in the same cycle as BBOX header acceptance -> bbox_pend stays 1; the next frame also sends BBOX.
- rst asserted at IMAGE payload beat 1000:
  - Next cycle: out_valid=0, busy=0, all readies 0.
  - A subsequent frame_start produces a correct full sequence from the header.

Source files
------------

// File: rtl/display_annot_pkg.sv
// rtl/display_annot_pkg.sv - shared packet codes, sequencer states and payload sizing
// Imported by the scheduler, its source mux and the annotator so all agree on type codes.
package display_annot_pkg;

    localparam int CNT_W = 22;

    localparam logic [2:0] PKT_IMAGE = 3'd1;
    localparam logic [2:0] PKT_BBOX  = 3'd2;
    localparam logic [2:0] PKT_LOGO  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEL     = 3'd1,
        ST_HDR     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_TRAILER = 3'd4
    } state_t;

    // Two pixels are packed per 64-bit word.
    function automatic int pixel_words(input int width, input int height);
        return (width * height) / 2;
    endfunction

endpackage

// File: rtl/display_annot_src_mux.sv
// rtl/display_annot_src_mux.sv - combinational 3:1 valid/data/ready steering by packet type
// Ports: en (payload phase), sel (packet type), out_ready (downstream ready),
//        bbox/img/logo valid+data in and ready out, src_valid/src_data to the sequencer.
module display_annot_src_mux
    import display_annot_pkg::*;
(
    input  logic        en,
    input  logic [2:0]  sel,
    input  logic        out_ready,
    input  logic        bbox_valid,
    input  logic [63:0] bbox_data,
    output logic        bbox_ready,
    input  logic        img_valid,
    input  logic [63:0] img_data,
    output logic        img_ready,
    input  logic        logo_valid,
    input  logic [63:0] logo_data,
    output logic        logo_ready,
    output logic        src_valid,
    output logic [63:0] src_data
);

    // Unselected sources, and every source outside the payload phase, see ready=0.
    always_comb begin
        src_valid  = 1'b0;
        src_data   = '0;
        bbox_ready = 1'b0;
        img_ready  = 1'b0;
        logo_ready = 1'b0;
        if (en) begin
            case (sel)
                PKT_BBOX: begin
                    src_valid  = bbox_valid;
                    src_data   = bbox_data;
                    bbox_ready = out_ready;
                end
                PKT_IMAGE: begin
                    src_valid = img_valid;
                    src_data  = img_data;
                    img_ready = out_ready;
                end
                PKT_LOGO: begin
                    src_valid  = logo_valid;
                    src_data   = logo_data;
                    logo_ready = out_ready;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/display_annot_scheduler.sv
// rtl/display_annot_scheduler.sv - per-frame BBOX/IMAGE/LOGO packet sequencer for the annotator
// Ports: clk, rst (sync, active-high); frame_start, logo_en, bbox_upd control inputs;
//        bbox/img/logo valid/data/ready sources; out_valid/out_data/out_last/out_ready stream;
//        busy (sequence active), overrun (frame_start dropped this cycle).
module display_annot_scheduler
    import display_annot_pkg::*;
#(
    parameter int FRAME_WIDTH  = 540,
    parameter int FRAME_HEIGHT = 540,
    parameter int MAX_BBOX     = 16,
    parameter int LOGO_WIDTH   = 540,
    parameter int LOGO_HEIGHT  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        logo_en,
    input  logic        bbox_upd,
    input  logic        bbox_valid,
    input  logic [63:0] bbox_data,
    output logic        bbox_ready,
    input  logic        img_valid,
    input  logic [63:0] img_data,
    output logic        img_ready,
    input  logic        logo_valid,
    input  logic [63:0] logo_data,
    output logic        logo_ready,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        overrun
);

    localparam int IMG_CNT  = pixel_words(FRAME_WIDTH, FRAME_HEIGHT);
    localparam int BBOX_CNT = MAX_BBOX;
    localparam int LOGO_CNT = pixel_words(LOGO_WIDTH, LOGO_HEIGHT);

    if (IMG_CNT >= (1 << CNT_W) || BBOX_CNT >= (1 << CNT_W) || LOGO_CNT >= (1 << CNT_W) ||
        IMG_CNT < 1 || BBOX_CNT < 1 || LOGO_CNT < 1) begin : g_bad_count
        $error("display_annot_scheduler: payload count does not fit the beat counter");
    end

    localparam logic [CNT_W-1:0] IMG_LAST  = CNT_W'(IMG_CNT - 1);
    localparam logic [CNT_W-1:0] BBOX_LAST = CNT_W'(BBOX_CNT - 1);
    localparam logic [CNT_W-1:0] LOGO_LAST = CNT_W'(LOGO_CNT - 1);

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bbox_pend_q, bbox_pend_d;
    logic             logo_q, logo_d;
    logic [CNT_W-1:0] last_idx;
    logic             mux_en;
    logic             src_valid;
    logic [63:0]      src_data;

    assign mux_en  = (state_q == ST_PAYLOAD);
    assign busy    = (state_q != ST_IDLE);
    assign overrun = frame_start && busy;

    display_annot_src_mux u_src_mux (
        .en         (mux_en),
        .sel        (sel_q),
        .out_ready  (out_ready),
        .bbox_valid (bbox_valid),
        .bbox_data  (bbox_data),
        .bbox_ready (bbox_ready),
        .img_valid  (img_valid),
        .img_data   (img_data),
        .img_ready  (img_ready),
        .logo_valid (logo_valid),
        .logo_data  (logo_data),
        .logo_ready (logo_ready),
        .src_valid  (src_valid),
        .src_data   (src_data)
    );

    always_comb begin
        case (sel_q)
            PKT_BBOX: last_idx = BBOX_LAST;
            PKT_LOGO: last_idx = LOGO_LAST;
            default:  last_idx = IMG_LAST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= PKT_IMAGE;
            cnt_q       <= '0;
            bbox_pend_q <= 1'b0;
            logo_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            bbox_pend_q <= bbox_pend_d;
            logo_q      <= logo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        bbox_pend_d = bbox_pend_q || bbox_upd;
        logo_d      = logo_q;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_SEL;
                    logo_d  = logo_en;
                    sel_d   = bbox_pend_q ? PKT_BBOX : PKT_IMAGE;
                end
            end
            ST_SEL: state_d = ST_HDR;
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = {61'b0, sel_q};
                if (out_ready) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
                    // A bbox_upd landing on this very cycle stays pending for the next frame.
                    if (sel_q == PKT_BBOX) bbox_pend_d = bbox_upd;
                end
            end
            ST_PAYLOAD: begin
                out_valid = src_valid;
                out_data  = src_data;
                if (src_valid && out_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == last_idx) state_d = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    case (sel_q)
                        PKT_BBOX: begin
                            sel_d   = PKT_IMAGE;
                            state_d = ST_HDR;
                        end
                        PKT_IMAGE: begin
                            if (logo_q) begin
                                sel_d   = PKT_LOGO;
                                state_d = ST_HDR;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_display_annot_scheduler.sv
// tb/tb_display_annot_scheduler.sv - randomized self-checking bench for display_annot_scheduler
module tb_display_annot_scheduler;

    localparam int FW = 16;
    localparam int FH = 6;
    localparam int MB = 4;
    localparam int LW = 8;
    localparam int LH = 3;
    localparam int N_IMG  = FW * FH / 2;
    localparam int N_LOGO = LW * LH / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        logo_en;
    logic        bbox_upd;
    logic        bbox_valid, img_valid, logo_valid;
    logic [63:0] bbox_data, img_data, logo_data;
    logic        bbox_ready, img_ready, logo_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    int          vpct [3];
    int          rpct;
    int          idx  [3];
    bit          hold [3];
    bit          sv   [3];
    logic [31:0] salt [3];
    logic [64:0] cap   [$];
    logic [64:0] exp_q [$];

    always #5 clk = ~clk;

    display_annot_scheduler #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .MAX_BBOX    (MB),
        .LOGO_WIDTH  (LW),
        .LOGO_HEIGHT (LH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .logo_en    (logo_en),
        .bbox_upd   (bbox_upd),
        .bbox_valid (bbox_valid),
        .bbox_data  (bbox_data),
        .bbox_ready (bbox_ready),
        .img_valid  (img_valid),
        .img_data   (img_data),
        .img_ready  (img_ready),
        .logo_valid (logo_valid),
        .logo_data  (logo_data),
        .logo_ready (logo_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Source word: per-source random tag in the top half, beat index in the bottom half.
    function automatic logic [63:0] mk(input int s, input int i);
        return {salt[s], 32'(i)};
    endfunction

    function automatic void add_pkt(input int s, input int n, input int code);
        exp_q.push_back({1'b0, 64'(code)});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, mk(s, idx[s] + i)});
        exp_q.push_back({1'b1, 64'd0});
    endfunction

    // Expected frame: optional BBOX, IMAGE, optional LOGO, each continuing its source's beats.
    function automatic void build_exp(input bit with_bbox, input bit with_logo);
        exp_q.delete();
        cap.delete();
        if (with_bbox) add_pkt(0, MB, 2);
        add_pkt(1, N_IMG, 1);
        if (with_logo) add_pkt(2, N_LOGO, 3);
    endfunction

    function automatic int stream_diff();
        int n;
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) return i;
        if (cap.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [64:0] word_or_x(input bit from_cap, input int i);
        if (from_cap) return (i < cap.size()) ? cap[i] : 'x;
        return (i < exp_q.size()) ? exp_q[i] : 'x;
    endfunction

    // Source/sink driver and protocol monitor: drive at negedge, observe at negedge+1.
    initial begin : drv
        logic        pv, pr, pl, prst;
        logic [63:0] pd;
        logic [2:0]  sr;
        logic [63:0] sd [3];
        pv = 1'b0; pr = 1'b0; pl = 1'b0; prst = 1'b1; pd = '0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 3; s++)
                if (!hold[s]) sv[s] = ($urandom_range(99) < vpct[s]);
            bbox_valid = sv[0]; bbox_data = mk(0, idx[0]);
            img_valid  = sv[1]; img_data  = mk(1, idx[1]);
            logo_valid = sv[2]; logo_data = mk(2, idx[2]);
            out_ready  = ($urandom_range(99) < rpct);
            #1;
            sr = {logo_ready, img_ready, bbox_ready};
            sd[0] = bbox_data; sd[1] = img_data; sd[2] = logo_data;
            if (pv && !pr && !prst) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             out_valid, out_data, out_last, pd, pl);
                end
            end
            checks++;
            if ($countones(sr) > 1 || (!busy && sr !== 3'b000)) begin
                errors++;
                $display("FAIL ready_steer: got readies=%b busy=%b, want at most one and none when idle",
                         sr, busy);
            end
            for (int s = 0; s < 3; s++) begin
                if (sr[s]) begin
                    checks++;
                    if (out_ready !== 1'b1 || out_valid !== sv[s] || out_data !== sd[s]) begin
                        errors++;
                        $display("FAIL passthru src%0d: got ordy=%b v=%b d=%h, want ordy=1 v=%b d=%h",
                                 s, out_ready, out_valid, out_data, sv[s], sd[s]);
                    end
                end
            end
            if (out_valid && out_ready && !rst) cap.push_back({out_last, out_data});
            for (int s = 0; s < 3; s++) begin
                if (sv[s] && sr[s] && !rst) begin
                    idx[s]++;
                    hold[s] = 1'b0;
                end else begin
                    hold[s] = sv[s];
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; prst = rst;
        end
    end

    task automatic start_frame(input logic le);
        @(negedge clk);
        frame_start = 1'b1;
        logo_en     = le;
        @(negedge clk);
        frame_start = 1'b0;
        logo_en     = 1'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (busy && n < 20000);
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s timeout: got busy=%b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    task automatic wait_cap(input int n);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            #2;
            c++;
        end while (cap.size() < n && c < 5000);
        checks++;
        if (cap.size() < n) begin
            errors++;
            $display("FAIL wait_cap: got %0d words, want %0d", cap.size(), n);
        end
    endtask

    task automatic pulse_upd();
        @(negedge clk);
        bbox_upd = 1'b1;
        @(negedge clk);
        bbox_upd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b busy=%b ovr=%b, want 0 0 0 0",
                     out_valid, out_last, busy, overrun);
        end
        checks++;
        if ({bbox_ready, img_ready, logo_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readies: got %b, want 000", {bbox_ready, img_ready, logo_ready});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bbox_image();
        int d;
        pulse_upd();
        build_exp(1'b1, 1'b0);
        start_frame(1'b0);
        wait_idle("bbox_image");
        d = stream_diff(); checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL bbox_image word %0d: got %h (n=%0d), want %h (n=%0d)",
                     d, word_or_x(1, d), cap.size(), word_or_x(0, d), exp_q.size());
        end
        build_exp(1'b0, 1'b0);
        start_frame(1'b0);
        wait_idle("bbox_cleared");
        d = stream_diff(); checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL bbox_cleared word %0d: got %h (n=%0d), want %h (n=%0d)",
                     d, word_or_x(1, d), cap.size(), word_or_x(0, d), exp_q.size());
        end
    endtask

    task automatic test_image_logo();
        int d;
        build_exp(1'b0, 1'b1);
        start_frame(1'b1);
        wait_idle("image_logo");
        d = stream_diff(); checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL image_logo word %0d: got %h (n=%0d), want %h (n=%0d)",
                     d, word_or_x(1, d), cap.size(), word_or_x(0, d), exp_q.size());
        end
    endtask

    task automatic test_random_stalls();
        int d;
        rpct = 50;
        vpct[0] = 70; vpct[1] = 60; vpct[2] = 70;
        for (int f = 0; f < 3; f++) begin
            bit b, l;
            b = 1'($urandom);
            l = 1'($urandom);
            if (b) pulse_upd();
            build_exp(b, l);
            start_frame(l);
            wait_idle("random_stalls");
            d = stream_diff(); checks++;
            if (d != -1) begin
                errors++;
                $display("FAIL random_stalls f%0d word %0d: got %h (n=%0d), want %h (n=%0d)",
                         f, d, word_or_x(1, d), cap.size(), word_or_x(0, d), exp_q.size());
            end
        end
        rpct = 100;
        vpct[0] = 100; vpct[1] = 100; vpct[2] = 100;
    endtask

    task automatic test_overrun();
        int d;
        build_exp(1'b0, 1'b0);
        start_frame(1'b0);
        wait_cap(11);
        @(negedge clk);
        frame_start = 1'b1;
        logo_en     = 1'b1;
        #2;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %b, want 1", overrun);
        end
        @(negedge clk);
        frame_start = 1'b0;
        #2;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b, want 0", overrun);
        end
        wait_idle("overrun");
        repeat (20) @(negedge clk);
        #2;
        d = stream_diff(); checks++;
        if (d != -1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_stream word %0d: got %h (n=%0d busy=%b), want %h (n=%0d busy=0)",
                     d, word_or_x(1, d), cap.size(), busy, word_or_x(0, d), exp_q.size());
        end
    endtask

    task automatic test_bbox_coincide();
        int d;
        pulse_upd();
        build_exp(1'b1, 1'b0);
        @(negedge clk);
        frame_start = 1'b1;
        logo_en     = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        bbox_upd = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b1 || out_ready !== 1'b1 || out_data !== 64'd2 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL coincide_hdr: got v=%b r=%b d=%h l=%b, want v=1 r=1 d=2 l=0",
                     out_valid, out_ready, out_data, out_last);
        end
        @(negedge clk);
        bbox_upd = 1'b0;
        wait_idle("coincide");
        d = stream_diff(); checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL coincide_frame word %0d: got %h (n=%0d), want %h (n=%0d)",
                     d, word_or_x(1, d), cap.size(), word_or_x(0, d), exp_q.size());
        end
        build_exp(1'b1, 1'b0);
        start_frame(1'b0);
        wait_idle("bbox_kept");
        d = stream_diff(); checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL bbox_kept word %0d: got %h (n=%0d), want %h (n=%0d)",
                     d, word_or_x(1, d), cap.size(), word_or_x(0, d), exp_q.size());
        end
        build_exp(1'b0, 1'b0);
        start_frame(1'b0);
        wait_idle("bbox_consumed");
        d = stream_diff(); checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL bbox_consumed word %0d: got %h (n=%0d), want %h (n=%0d)",
                     d, word_or_x(1, d), cap.size(), word_or_x(0, d), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int d;
        build_exp(1'b0, 1'b1);
        start_frame(1'b1);
        wait_cap(21);
        pulse_upd();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            {bbox_ready, img_ready, logo_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: got v=%b busy=%b l=%b rdy=%b, want 0 0 0 000",
                     out_valid, busy, out_last, {bbox_ready, img_ready, logo_ready});
        end
        build_exp(1'b0, 1'b1);
        start_frame(1'b1);
        wait_idle("after_reset");
        d = stream_diff(); checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL after_reset word %0d: got %h (n=%0d), want %h (n=%0d)",
                     d, word_or_x(1, d), cap.size(), word_or_x(0, d), exp_q.size());
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        logo_en     = 1'b0;
        bbox_upd    = 1'b0;
        rpct        = 100;
        for (int s = 0; s < 3; s++) begin
            vpct[s] = 100;
            idx[s]  = 0;
            hold[s] = 1'b0;
            sv[s]   = 1'b0;
            salt[s] = {$urandom_range(32'h0fff_ffff), 4'(s)};
        end
        test_reset();
        test_bbox_image();
        test_image_logo();
        test_random_stalls();
        test_overrun();
        test_bbox_coincide();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
